// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two CPU-side masters, the arbiter and the memory-bus slave.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ready, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rdata, m1_err,
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rvalid, bus_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ready, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rdata, m1_err,
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rvalid, bus_rdata,
    input  busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the single-slave CPU memory bus, one transaction
// in flight at a time, with a BUSY-cycle timeout that completes with an error flag.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              owner_reg;
  logic              last_owner_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [1:0]        req;
  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];
  logic [1:0]        ready;
  logic [DATA_W-1:0] rdata_out [2];
  logic [1:0]        err_out;
  logic              grant_sel;
  logic              timeout_hit;

  assign req         = {bif.m1_req, bif.m0_req};
  assign we_in       = {bif.m1_we, bif.m0_we};
  assign addr_in[0]  = bif.m0_addr;
  assign addr_in[1]  = bif.m1_addr;
  assign wdata_in[0] = bif.m0_wdata;
  assign wdata_in[1] = bif.m1_wdata;

  // On a tie the master that did not own the previous transaction wins.
  always_comb begin
    grant_sel = req[1];
    if (req == 2'b11) begin
      grant_sel = ~last_owner_reg;
    end
  end

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (|req) state_next = BUSY;
      BUSY: if (bif.bus_rvalid || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            owner_reg <= grant_sel;
            we_reg    <= we_in[grant_sel];
            addr_reg  <= addr_in[grant_sel];
            wdata_reg <= wdata_in[grant_sel];
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // A slave answer in the last allowed cycle still counts as a normal completion.
          if (bif.bus_rvalid) begin
            rdata_reg <= we_reg ? '0 : bif.bus_rdata;
            err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        RESP: begin
          last_owner_reg <= owner_reg;
        end
        default: begin
        end
      endcase
    end
  end

  // Response fields are forced to zero for the non-owner and outside RESP.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign ready[gi]     = (state_reg == RESP) && (owner_reg == 1'(gi));
      assign rdata_out[gi] = ready[gi] ? rdata_reg : '0;
      assign err_out[gi]   = ready[gi] & err_reg;
    end
  endgenerate

  assign bif.m0_ready = ready[0];
  assign bif.m0_rdata = rdata_out[0];
  assign bif.m0_err   = err_out[0];
  assign bif.m1_ready = ready[1];
  assign bif.m1_rdata = rdata_out[1];
  assign bif.m1_err   = err_out[1];

  assign bif.bus_valid = (state_reg == BUSY);
  assign bif.bus_we    = we_reg;
  assign bif.bus_addr  = addr_reg;
  assign bif.bus_wdata = wdata_reg;
  assign bif.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: masters push expected completions, a monitor pops and
// compares them, and a slave model answers after a per-address number of BUSY cycles.
module tb_bus_arbiter;

  localparam int TIMEOUT = 8;
  localparam int NEVER   = 100;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   grant_log[$];

  int          slave_k  [logic [31:0]];
  logic [31:0] slave_rd [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: answers on BUSY cycle k of the transaction at that address, drives junk otherwise.
  int scnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      scnt = 0;
      bif.bus_rvalid = 1'b0;
    end else if (bif.bus_valid) begin
      scnt++;
      if (slave_k.exists(bif.bus_addr) && scnt == slave_k[bif.bus_addr]) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = slave_rd[bif.bus_addr];
      end else begin
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = $urandom;
      end
    end else begin
      scnt = 0;
      bif.bus_rvalid = ($urandom_range(0, 3) == 0);
      bif.bus_rdata  = $urandom;
    end
  end

  // Monitor: grant rule, bus field stability, BUSY length, and scoreboard pops on ready.
  logic        prev_valid = 1'b0;
  logic        prev_idle_req = 1'b0;
  logic        idle_r0 = 1'b0, idle_r1 = 1'b0;
  logic        last_owner = 1'b1;
  logic        cur_owner = 1'b0;
  logic        prev_rdy0 = 1'b0, prev_rdy1 = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic        snap_we;
  int          run_len = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0; prev_idle_req = 1'b0; last_owner = 1'b1;
      prev_rdy0 = 1'b0; prev_rdy1 = 1'b0; run_len = 0;
    end else begin
      logic exp_owner;
      int   exp_len;
      exp_t e;
      if (prev_idle_req) check("grant_latency", bif.bus_valid, 1);
      if (bif.bus_valid && !prev_valid) begin
        exp_owner = (idle_r0 && idle_r1) ? !last_owner : idle_r1;
        cur_owner = (bif.bus_addr == bif.m1_addr) ? 1'b1 : 1'b0;
        check("grant_owner", cur_owner, exp_owner);
        check("bus_addr", bif.bus_addr, cur_owner ? bif.m1_addr : bif.m0_addr);
        check("bus_we", bif.bus_we, cur_owner ? bif.m1_we : bif.m0_we);
        check("bus_wdata", bif.bus_wdata, cur_owner ? bif.m1_wdata : bif.m0_wdata);
        grant_log.push_back(cur_owner);
        snap_addr = bif.bus_addr; snap_we = bif.bus_we; snap_wdata = bif.bus_wdata;
        run_len = 1;
      end else if (bif.bus_valid) begin
        run_len++;
        if (bif.bus_addr !== snap_addr || bif.bus_we !== snap_we || bif.bus_wdata !== snap_wdata)
          check("bus_stable", {bif.bus_we, bif.bus_addr[30:0]}, {snap_we, snap_addr[30:0]});
      end else if (prev_valid) begin
        exp_len = (slave_k[snap_addr] < TIMEOUT) ? slave_k[snap_addr] : TIMEOUT;
        check("busy_len", run_len, exp_len);
        check("ready_after_busy", cur_owner ? bif.m1_ready : bif.m0_ready, 1);
      end
      check("busy_flag", bif.busy, bif.bus_valid | bif.m0_ready | bif.m1_ready);
      if (bif.m0_ready && bif.m1_ready) check("dual_ready", 1, 0);
      if (bif.m0_ready) begin
        check("m0_pulse", prev_rdy0, 0);
        if (exp_q0.size() == 0) check("m0_unexpected_ready", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check("m0_rdata", bif.m0_rdata, e.rdata);
          check("m0_err", bif.m0_err, e.err);
        end
        last_owner = 1'b0;
      end else if (bif.m0_rdata !== '0 || bif.m0_err !== 1'b0) begin
        check("m0_idle_out", {bif.m0_err, bif.m0_rdata[30:0]}, 0);
      end
      if (bif.m1_ready) begin
        check("m1_pulse", prev_rdy1, 0);
        if (exp_q1.size() == 0) check("m1_unexpected_ready", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check("m1_rdata", bif.m1_rdata, e.rdata);
          check("m1_err", bif.m1_err, e.err);
        end
        last_owner = 1'b1;
      end else if (bif.m1_rdata !== '0 || bif.m1_err !== 1'b0) begin
        check("m1_idle_out", {bif.m1_err, bif.m1_rdata[30:0]}, 0);
      end
      if (!bif.busy) begin
        idle_r0 = bif.m0_req;
        idle_r1 = bif.m1_req;
      end
      prev_idle_req = !bif.busy && (bif.m0_req || bif.m1_req);
      prev_valid = bif.bus_valid;
      prev_rdy0 = bif.m0_ready;
      prev_rdy1 = bif.m1_ready;
    end
  end

  // Issue one transaction from a master at a negedge and hold it until its ready.
  task automatic issue(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int k, input logic [31:0] rd);
    exp_t e;
    logic seen;
    slave_k[addr]  = k;
    slave_rd[addr] = rd;
    e.err   = (k > TIMEOUT);
    e.rdata = (e.err || we) ? 32'h0 : rd;
    if (m == 0) begin
      exp_q0.push_back(e);
      bif.m0_we = we; bif.m0_addr = addr; bif.m0_wdata = wdata; bif.m0_req = 1'b1;
    end else begin
      exp_q1.push_back(e);
      bif.m1_we = we; bif.m1_addr = addr; bif.m1_wdata = wdata; bif.m1_req = 1'b1;
    end
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      seen = (m == 0) ? bif.m0_ready : bif.m1_ready;
    end
    if (!seen) check("ready_wait", 0, 1);
    if (m == 0) bif.m0_req = 1'b0;
    else        bif.m1_req = 1'b0;
  endtask

  initial begin
    bif.m0_req = 0; bif.m0_we = 0; bif.m0_addr = 0; bif.m0_wdata = 0;
    bif.m1_req = 0; bif.m1_we = 0; bif.m1_addr = 0; bif.m1_wdata = 0;
    bif.bus_rvalid = 0; bif.bus_rdata = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus_valid", bif.bus_valid, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_m0_ready", bif.m0_ready, 0);
    check("rst_m1_ready", bif.m1_ready, 0);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_bus_wdata", bif.bus_wdata, 0);
    check("rst_bus_we", bif.bus_we, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h0000_0300, 32'h0, NEVER, 32'h1111_1111);
    issue(0, 1'b0, 32'h0000_0400, 32'h0, TIMEOUT, 32'hA5A5_A5A5);
    issue(0, 1'b0, 32'h0000_0440, 32'h0, TIMEOUT + 1, 32'h5A5A_5A5A);
    issue(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 1, 32'hCAFE_F00D);

    grant_log.delete();
    fork
      begin
        issue(0, 1'b0, 32'h0000_1000, 32'h0, 1, 32'h0000_1010);
        issue(0, 1'b1, 32'h0000_1004, 32'h0000_0055, 1, 32'h0000_1014);
      end
      begin
        issue(1, 1'b0, 32'h0000_2000, 32'h0, 1, 32'h0000_2020);
        issue(1, 1'b0, 32'h0000_2004, 32'h0, 1, 32'h0000_2024);
      end
    join
    check("contend_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("contend_order", grant_log[i], i % 2);

    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(0, 1'($urandom_range(0, 1)), 32'h1000_0000 + 32'(i * 4), $urandom,
              $urandom_range(1, TIMEOUT + 2), $urandom);
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(1, 1'($urandom_range(0, 1)), 32'h2000_0000 + 32'(i * 4), $urandom,
              $urandom_range(1, TIMEOUT + 2), $urandom);
      end
    join
    repeat (3) @(negedge clk);

    slave_k[32'h0000_0500] = NEVER;
    bif.m0_we = 1'b0; bif.m0_addr = 32'h0000_0500; bif.m0_req = 1'b1;
    for (int c = 0; c < 20 && !bif.bus_valid; c++) @(negedge clk);
    check("pre_reset_valid", bif.bus_valid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_bus_valid", bif.bus_valid, 0);
    check("async_busy", bif.busy, 0);
    check("async_m0_ready", bif.m0_ready, 0);
    bif.m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    fork
      issue(0, 1'b0, 32'h0000_1100, 32'h0, 2, 32'h0BAD_CAFE);
      issue(1, 1'b0, 32'h0000_2100, 32'h0, 2, 32'h0000_FEED);
    join
    check("post_reset_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("post_reset_first", grant_log[0], 0);
      check("post_reset_second", grant_log[1], 1);
    end

    repeat (3) @(negedge clk);
    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, single-slave arbiter for the CPU memory bus.
- Shares the BUS_controller port between master 0 (instruction fetch) and master 1 (load/store unit).
- Latches one request at a time, drives the bus until the slave returns rvalid, then returns rdata to the owning master.
- Round-robin fairness; a timeout counter guarantees forward progress if the slave never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum BUSY cycles without bus_rvalid before an error completion (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ready.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  DATA_W  read data, valid while m0_ready=1.
- m0_err  out  1  timeout flag, valid while m0_ready=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err: same as master 0, for master 1.
- bus_valid  out  1  request strobe to slave (drives BUS_data_valid).
- bus_we  out  1  write enable to slave.
- bus_addr  out  ADDR_W  address to slave.
- bus_wdata  out  DATA_W  write data to slave.
- bus_rvalid  in  1  slave completion, for both reads and writes.
- bus_rdata  in  DATA_W  slave read data, sampled when bus_rvalid=1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, owner=0, last_owner=1 so master 0 wins the first tie.
  - All outputs 0; internal address/data/we registers and the timeout counter 0.
- Reset is asynchronous: asserting rst in any state drops bus_valid and all outputs the same instant. No ready is issued for an aborted transaction.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master != last_owner.
  - On grant: register owner, addr, wdata, we from the granted master; clear the counter; go to BUSY.
- BUSY:
  - bus_valid=1; bus_we/addr/wdata come from the registered copies and stay stable for the whole state.
  - Counter increments each cycle.
  - If bus_rvalid=1: capture bus_rdata (reads only; 0 for writes), err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rdata=0, err=1, go to RESP.
  - bus_rvalid takes priority over timeout in the same cycle.
- RESP:
  - m<owner>_ready=1 for exactly this cycle, with rdata/err.
  - The non-owner's ready/err/rdata stay 0.
  - last_owner<=owner; go to IDLE.
- Outside RESP, m*_rdata and m*_err are 0.
- Latency:
  - req sampled in IDLE at cycle N; bus_valid from N+1.
  - If rvalid arrives at N+1, ready is at N+2 and the FSM returns to IDLE at N+3.
  - Minimum is 3 cycles per transaction.
- Master rules:
  - A master must hold req and its fields stable until it sees ready.
  - req still high in the IDLE cycle after ready is a new request.
  - Dropping req during BUSY does not cancel; the completion is still delivered.
- bus_rvalid or bus_rdata arriving in IDLE or RESP is ignored.
- With both masters continuously requesting, grants alternate 0,1,0,1... Neither master waits more than one foreign transaction.
- Counter width is clog2(TIMEOUT+1); it never wraps, because it is reset on entry to BUSY.

Test Plan:
- Single read: m0_req, we=0, addr=0x0000_0100; slave rvalid 2 cycles after bus_valid with rdata=0xDEAD_BEEF -> bus_addr=0x100 stable, m0_ready one cycle with rdata=0xDEADBEEF, err=0, m1_ready=0.
- Single write: m1_req, we=1, addr=0x200, wdata=0x1234_5678; slave rvalid on first BUSY cycle -> bus_we=1, bus_wdata=0x12345678, m1_ready exactly 2 cycles after grant, m1_rdata=0.
- Contention: m0_req and m1_req both held high for 4 transactions, slave answers in 1 cycle -> grant order 0,1,0,1; each ready a single pulse; busy low exactly one cycle between transactions.
- Timeout: TIMEOUT=8, m0 read, slave never asserts rvalid -> bus_valid high exactly 8 cycles, then m0_ready=1 with err=1, rdata=0; next request is accepted normally.
- rvalid on the timeout cycle: TIMEOUT=8, rvalid on the 8th BUSY cycle with rdata=0xA5A5_A5A5 -> err=0, rdata=0xA5A5A5A5.
- Reset mid-BUSY: assert rst while bus_valid=1 -> bus_valid and busy drop asynchronously, no m*_ready pulse; after rst release, a simultaneous m0/m1 request is granted to m0 first.
